// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction-fetch stage feeding the decoder.
//
// Owns the PC and issues in-order requests to instruction memory. The PC of every
// accepted request is remembered in a pending queue. When the instruction comes back it
// is paired with that PC and pushed into a BUF_DEPTH-entry FIFO. The FIFO head is
// presented to ID.
//
// A single credit pool limits in-flight requests plus buffered entries to BUF_DEPTH.
// In-flight requests include those whose responses will be discarded after a flush.
// Because of this the FIFO can never overflow, and imem_rvalid needs no back-pressure.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pc_stall                       freeze PC and inhibit new requests
//   if_stall                       ID not accepting; hold FIFO head
//   if_flush                       drop fetched/in-flight work and redirect the PC
//   jp_taken, jp_target_pc         decoder jump redirect
//   rob_commit_br_taken,
//   br_target_pc                   committed-branch redirect (wins over the jump)
//   imem_req, imem_addr, imem_gnt  request handshake
//   imem_rvalid, imem_rdata        in-order response, no back-pressure
//   if_en, if_pc, if_inst          FIFO head toward ID (zero when empty)
//
// Optional build macro IF_PERF_CNT_EN adds the following saturating 32-bit outputs:
//   perf_fetch_cnt   counts fired requests
//   perf_flush_cnt   counts flush cycles
module if_fetch_buffer #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter int unsigned         BUF_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_stall,
  input  logic                  if_stall,
  input  logic                  if_flush,
  input  logic                  jp_taken,
  input  logic [PC_WIDTH-1:0]   jp_target_pc,
  input  logic                  rob_commit_br_taken,
  input  logic [PC_WIDTH-1:0]   br_target_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_en,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [INST_WIDTH-1:0] if_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int unsigned PtrW  = $clog2(BUF_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned UsedW = CntW + 1;

  // The redirect target is chosen by rob_commit_br_taken alone; a flush with neither
  // source set still lands on jp_target_pc.
  logic unused_jp_taken;
  assign unused_jp_taken = jp_taken;

  // Low through the reset cycle so that no request escapes while rst_n is asserted.
  logic run_q;

  logic [PC_WIDTH-1:0] pc_q, pc_d;

  logic [PC_WIDTH-1:0] pend_mem_q [BUF_DEPTH];
  logic [PtrW-1:0]     pend_wr_q, pend_rd_q;
  logic [CntW-1:0]     pend_cnt_q, pend_cnt_d;
  logic [CntW-1:0]     disc_q, disc_d;

  logic [PC_WIDTH-1:0]   fifo_pc_q   [BUF_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_q [BUF_DEPTH];
  logic [PtrW-1:0]       fifo_wr_q, fifo_rd_q;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;

  logic [CntW-1:0]  outstanding;
  logic [UsedW-1:0] used;
  logic             fire, rsp_any, rsp_drop, rsp_take, push, pop;

  assign outstanding = pend_cnt_q + disc_q;
  assign used        = UsedW'(outstanding) + UsedW'(fifo_cnt_q);

  assign imem_req  = run_q & ~pc_stall & ~if_flush & (used < UsedW'(BUF_DEPTH));
  assign imem_addr = pc_q;

  assign fire     = imem_req & imem_gnt;
  assign rsp_any  = imem_rvalid & (outstanding != '0);
  assign rsp_drop = imem_rvalid & (disc_q != '0);
  assign rsp_take = imem_rvalid & (disc_q == '0) & (pend_cnt_q != '0);
  assign push     = rsp_take & ~if_flush;
  assign pop      = if_en & ~if_stall & ~if_flush;

  assign if_en   = (fifo_cnt_q != '0);
  assign if_pc   = if_en ? fifo_pc_q[fifo_rd_q]   : '0;
  assign if_inst = if_en ? fifo_inst_q[fifo_rd_q] : '0;

  always_comb begin
    pc_d       = pc_q;
    pend_cnt_d = pend_cnt_q;
    disc_d     = disc_q;
    fifo_cnt_d = fifo_cnt_q;
    if (if_flush) begin
      pc_d       = rob_commit_br_taken ? br_target_pc : jp_target_pc;
      pend_cnt_d = '0;
      fifo_cnt_d = '0;
      // Everything still in flight must be swallowed, except a response landing right now.
      disc_d     = outstanding - CntW'(rsp_any);
    end else begin
      if (fire) pc_d = pc_q + PC_WIDTH'(4);
      pend_cnt_d = pend_cnt_q + CntW'(fire) - CntW'(rsp_take);
      fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
      if (rsp_drop) disc_d = disc_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
      disc_q     <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      pc_q       <= pc_d;
      pend_cnt_q <= pend_cnt_d;
      disc_q     <= disc_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (if_flush) begin
        pend_wr_q <= '0;
        pend_rd_q <= '0;
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (fire)     pend_wr_q <= pend_wr_q + PtrW'(1);
        if (rsp_take) pend_rd_q <= pend_rd_q + PtrW'(1);
        if (push)     fifo_wr_q <= fifo_wr_q + PtrW'(1);
        if (pop)      fifo_rd_q <= fifo_rd_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset; validity is carried by the counters above.
  always_ff @(posedge clk) begin
    if (fire) pend_mem_q[pend_wr_q] <= pc_q;
    if (push) begin
      fifo_pc_q[fifo_wr_q]   <= pend_mem_q[pend_rd_q];
      fifo_inst_q[fifo_wr_q] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fire && perf_fetch_cnt != 32'hFFFF_FFFF)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_flush && perf_flush_cnt != 32'hFFFF_FFFF) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed-plus-random bench for if_fetch_buffer.
// The bench models instruction memory with a per-request response latency. Every granted
// request pushes its {pc, inst} onto a scoreboard queue. Each pop toward ID is compared
// against the front of that queue. A reference model of PC, credits and FIFO occupancy
// predicts imem_req, imem_addr and if_en every cycle.
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_stall = 1'b0, if_stall = 1'b0, if_flush = 1'b0;
  logic        jp_taken = 1'b0, rob_commit_br_taken = 1'b0;
  logic [31:0] jp_target_pc = '0, br_target_pc = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        if_en;
  logic [31:0] if_pc, if_inst;

  if_fetch_buffer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pc_stall            (pc_stall),
    .if_stall            (if_stall),
    .if_flush            (if_flush),
    .jp_taken            (jp_taken),
    .jp_target_pc        (jp_target_pc),
    .rob_commit_br_taken (rob_commit_br_taken),
    .br_target_pc        (br_target_pc),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_gnt            (imem_gnt),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .if_en               (if_en),
    .if_pc               (if_pc),
    .if_inst             (if_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mem_t;

  mem_t        memq[$];   // requests accepted by memory, not yet answered
  logic [31:0] exp_q[$];  // fired, unflushed PCs awaiting consumption
  int          fcnt;      // entries delivered into the FIFO, not yet popped
  logic [31:0] model_pc;
  int          cyc;
  int          lat;
  bit          gnt_en;
  int          vectors;
  int          miscompares;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with this cycle's control inputs already set; returns at the next
  // negedge.
  task automatic cycle();
    bit          resp, exp_req, fire, pop;
    mem_t        m;
    logic [31:0] e;
    resp = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      resp        = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = gnt_en;
    #1;
    exp_req = !pc_stall && !if_flush && (memq.size() + fcnt < 4);
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, model_pc);
    chk("if_en", if_en, fcnt > 0);
    if (fcnt == 0) chk("if_pc_idle", if_pc, 32'h0);
    fire = exp_req && gnt_en;
    pop  = fcnt > 0 && !if_stall && !if_flush;
    if (pop) begin
      e = exp_q.pop_front();
      chk("if_pc", if_pc, e);
      chk("if_inst", if_inst, inst_of(e));
      fcnt--;
    end
    if (resp) begin
      m = memq.pop_front();
      if (m.live && !if_flush) fcnt++;
    end
    if (if_flush) begin
      fcnt = 0;
      exp_q.delete();
      foreach (memq[i]) memq[i].live = 1'b0;
      model_pc = rob_commit_br_taken ? br_target_pc : jp_target_pc;
    end
    if (fire) begin
      memq.push_back('{addr: model_pc, due: cyc + lat, live: 1'b1});
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset at a negedge (possibly mid-stream) with stale responses on the bus.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_if_en", if_en, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_cycle_req", imem_req, 1'b0);
    chk("rst_cycle_if_en", if_en, 1'b0);
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    memq.delete();
    exp_q.delete();
    fcnt     = 0;
    model_pc = 32'h0;
  endtask

  task automatic flush(input bit br, input logic [31:0] jt, input logic [31:0] bt);
    if_flush            = 1'b1;
    jp_taken            = 1'b1;
    rob_commit_br_taken = br;
    jp_target_pc        = jt;
    br_target_pc        = bt;
    cycle();
    if_flush            = 1'b0;
    jp_taken            = 1'b0;
    rob_commit_br_taken = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; lat = 1; gnt_en = 1'b1;
    fcnt = 0; model_pc = 32'h0;
    do_reset();

    // Streaming fetch with 1-cycle memory.
    repeat (12) cycle();

    // ID stalled: fill to capacity, then release.
    if_stall = 1'b1;
    repeat (8) cycle();
    chk("full_no_req", imem_req, 1'b0);
    chk("full_if_en", if_en, 1'b1);
    if_stall = 1'b0;
    repeat (8) cycle();

    // Flush with responses in flight, jump redirect.
    lat = 2;
    repeat (4) cycle();
    flush(1'b0, 32'h100, 32'h0);
    chk("flush_if_en_next", if_en, 1'b0);
    repeat (10) cycle();

    // Branch wins when both redirect sources are set.
    lat = 1;
    flush(1'b1, 32'h100, 32'h200);
    chk("br_wins_addr", imem_addr, 32'h200);
    repeat (6) cycle();

    // PC wraps silently at the top of the address space.
    flush(1'b0, 32'hFFFF_FFF8, 32'h0);
    repeat (8) cycle();

    // PC stall with a non-empty FIFO.
    pc_stall = 1'b1;
    repeat (3) cycle();
    pc_stall = 1'b0;
    repeat (6) cycle();

    // Reset mid-stream with several requests outstanding.
    lat = 4;
    repeat (5) cycle();
    do_reset();
    lat = 1;
    repeat (10) cycle();

    // Random mix of stalls, grants, latencies and flushes.
    for (int i = 0; i < 300; i++) begin
      gnt_en              = ($urandom_range(0, 3) != 0);
      if_stall            = ($urandom_range(0, 3) == 0);
      pc_stall            = ($urandom_range(0, 5) == 0);
      if_flush            = ($urandom_range(0, 19) == 0);
      jp_taken            = $urandom_range(0, 1) != 0;
      rob_commit_br_taken = $urandom_range(0, 1) != 0;
      jp_target_pc        = {$urandom_range(0, 1023), 2'b00};
      br_target_pc        = {$urandom_range(1024, 4095), 2'b00};
      lat                 = $urandom_range(1, 4);
      cycle();
    end
    gnt_en = 1'b1; if_stall = 1'b0; pc_stall = 1'b0; if_flush = 1'b0;
    jp_taken = 1'b0; rob_commit_br_taken = 1'b0; lat = 1;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
